// File: rtl/dsp_addsub_simd.sv
// dsp_addsub_simd: SIMD signed add/sub with per-lane wrap or saturate,
// STAGES-deep pipeline sharing one valid/ready handshake.
module dsp_addsub_simd #(
  parameter int WIDTH  = 8,
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op,
  input  logic                   sat,
  input  logic [WIDTH*LANES-1:0] a,
  input  logic [WIDTH*LANES-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*LANES-1:0] y,
  output logic [LANES-1:0]       ovf
);
  localparam int WL = WIDTH * LANES;

  logic             en;
  logic [WL-1:0]    y_c;
  logic [LANES-1:0] ovf_c;

  // Each lane is sign-extended by one bit so carries never leak across lanes.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH:0]   sa;
    logic [WIDTH:0]   sb;
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] max_v;
    logic [WIDTH-1:0] min_v;
    logic [WIDTH-1:0] y_l;

    assign sa    = {a[i*WIDTH+WIDTH-1], a[i*WIDTH +: WIDTH]};
    assign sb    = {b[i*WIDTH+WIDTH-1], b[i*WIDTH +: WIDTH]};
    assign s     = op ? (sa - sb) : (sa + sb);
    assign max_v = {1'b0, {(WIDTH-1){1'b1}}};
    assign min_v = {1'b1, {(WIDTH-1){1'b0}}};

    assign ovf_c[i] = s[WIDTH] ^ s[WIDTH-1];
    assign y_l = (sat && ovf_c[i]) ? (s[WIDTH] ? min_v : max_v)
                                   : s[WIDTH-1:0];
    assign y_c[i*WIDTH +: WIDTH] = y_l;
  end

  logic [STAGES-1:0] vld;
  logic [WL-1:0]     yq [STAGES];
  logic [LANES-1:0]  oq [STAGES];

  assign out_valid = vld[STAGES-1];
  assign en        = out_ready | ~out_valid;
  assign in_ready  = en;
  assign y         = yq[STAGES-1];
  assign ovf       = oq[STAGES-1];

  // Whole pipe shifts in lockstep; bubbles travel like beats.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) begin
        yq[i] <= '0;
        oq[i] <= '0;
      end
    end else if (en) begin
      vld[0] <= in_valid;
      yq[0]  <= y_c;
      oq[0]  <= ovf_c;
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
        yq[i]  <= yq[i-1];
        oq[i]  <= oq[i-1];
      end
    end
  end

endmodule
